// File: rtl/dmem_lsu_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-memory load/store sequencer.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Byte lane = addr[1:0], half lane = addr[1]; sign-extend unless is_unsigned.
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        is_unsigned,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_fmt.sv
// Combinational lane formatter: load extract/extend and sub-word store merge.
module dmem_lsu_fmt
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  always_comb begin
    load_val = load_extract(size, is_unsigned, addr_lo, word_in);
    merged   = store_merge(size, addr_lo, word_in, wdata);
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer: one request in flight, sub-word stores done as read-modify-write.
module dmem_lsu_ctrl
  import dmem_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until that edge, ready never waits on valid.

  lsu_state_e  state, state_nxt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        req_err;
  logic        accept;

  assign accept  = (state == ST_IDLE) && req_valid;
  assign req_err = (req_size == 2'b11)
                 | ((req_size == SZ_H) & req_addr[0])
                 | ((req_size == SZ_W) & (|req_addr[1:0]))
                 | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  dmem_lsu_fmt u_fmt (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (addr_q[1:0]),
    .word_in     (mem_rd),
    .wdata       (wdata_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      err_q   <= req_err;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      data_q  <= '0;
    end else if (state == ST_RD) begin
      data_q  <= we_q ? merged : load_val;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                       state_nxt = ST_RESP;
          else if (req_we && req_size == SZ_W) state_nxt = ST_WR;
          else                               state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        mem_a     = {addr_q[31:2], 2'b00};
        state_nxt = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_a     = {addr_q[31:2], 2'b00};
        mem_wd    = (size_q == SZ_W) ? wdata_q : data_q;
        mem_we    = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        // Stores and errored requests report zero data.
        rsp_rdata = (err_q || we_q) ? 32'h0 : data_q;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a 64-word memory model and a response scoreboard.
module tb_dmem_lsu_ctrl;
  import dmem_lsu_pkg::*;

  typedef struct packed {
    logic [3:0]  lat;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  we_cnt;
    logic [3:0]  we_cyc;
    logic [31:0] wa;
    logic [31:0] wd;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  logic do_preload;
  logic [31:0] mem [64];

  dmem_lsu_ctrl #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // Clock / reset and memory model
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i <= 8) ? 32'hDEADBEEF : 32'h0;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic err, input logic [31:0] rd,
                              input int wc, input int wcy, input logic [31:0] wa,
                              input logic [31:0] wd);
    exp_t e;
    e.lat = 4'(lat); e.err = err; e.rdata = rd;
    e.we_cnt = 2'(wc); e.we_cyc = 4'(wcy); e.wa = wa; e.wd = wd;
    return e;
  endfunction

  // Driver tasks
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
    bit ok;
    ok = 0;
    exp_q.push_back(e);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 (addr %h)", addr);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n_before);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_seen > n_before) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", rsp_seen, n_before + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
    int n;
    n = rsp_seen;
    issue(we, sz, uns, addr, wdata, e);
    wait_rsp(n);
  endtask

  // Monitor / scoreboard
  initial begin
    int   cnt, lat, wcnt, wcyc;
    bit   trk, seen;
    logic [31:0] wa, wd;
    exp_t e;
    trk = 0; seen = 0; cnt = 0; lat = 0; wcnt = 0; wcyc = 0; wa = 0; wd = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trk = 0;
        continue;
      end
      if (trk) begin
        cnt++;
        if (mem_we) begin wcnt++; wcyc = cnt; wa = mem_a; wd = mem_wd; end
        if (rsp_valid && !seen) begin seen = 1; lat = cnt; end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rdata %h err %b expected none", rsp_rdata, rsp_err);
          end else begin
            e = exp_q.pop_front();
            check("rsp_latency", 32'(lat), 32'(e.lat));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("mem_we_pulses", 32'(wcnt), 32'(e.we_cnt));
            if (e.we_cnt != 0) begin
              check("mem_we_cycle", 32'(wcyc), 32'(e.we_cyc));
              check("mem_a", wa, e.wa);
              check("mem_wd", wd, e.wd);
            end
          end
          rsp_seen++;
          trk = 0;
        end
      end
      if (req_valid && req_ready) begin
        trk = 1; seen = 0; cnt = 0; lat = 0; wcnt = 0; wcyc = 0; wa = 0; wd = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int n;
    rst_n = 1'b0; do_preload = 1'b1;
    req_valid = 0; req_we = 0; req_size = SZ_B; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 do_preload = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads of a preloaded word
    xact(0, SZ_W, 0, 32'h0, 0, mk(2, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    xact(0, SZ_B, 0, 32'h1, 0, mk(2, 0, 32'hFFFFFFBE, 0, 0, 0, 0));
    xact(0, SZ_B, 1, 32'h1, 0, mk(2, 0, 32'h000000BE, 0, 0, 0, 0));
    xact(0, SZ_H, 0, 32'h2, 0, mk(2, 0, 32'hFFFFDEAD, 0, 0, 0, 0));
    xact(0, SZ_H, 1, 32'h2, 0, mk(2, 0, 32'h0000DEAD, 0, 0, 0, 0));
    xact(0, SZ_B, 0, 32'h0, 0, mk(2, 0, 32'hFFFFFFEF, 0, 0, 0, 0));
    xact(0, SZ_B, 1, 32'h3, 0, mk(2, 0, 32'h000000DE, 0, 0, 0, 0));
    xact(0, SZ_H, 0, 32'h0, 0, mk(2, 0, 32'hFFFFBEEF, 0, 0, 0, 0));

    // Sub-word and word stores
    xact(1, SZ_B, 0, 32'h6, 32'h12, mk(3, 0, 32'h0, 1, 2, 32'h4, 32'hDE12BEEF));
    xact(0, SZ_W, 0, 32'h4, 0, mk(2, 0, 32'hDE12BEEF, 0, 0, 0, 0));
    xact(1, SZ_W, 0, 32'h10, 32'h01234567, mk(2, 0, 32'h0, 1, 1, 32'h10, 32'h01234567));
    xact(0, SZ_B, 0, 32'h13, 0, mk(2, 0, 32'h00000001, 0, 0, 0, 0));
    xact(0, SZ_B, 0, 32'h12, 0, mk(2, 0, 32'h00000023, 0, 0, 0, 0));
    xact(0, SZ_H, 0, 32'h10, 0, mk(2, 0, 32'h00004567, 0, 0, 0, 0));
    xact(1, SZ_H, 0, 32'h16, 32'h5555CAFE, mk(3, 0, 32'h0, 1, 2, 32'h14, 32'hCAFEBEEF));
    xact(0, SZ_W, 0, 32'h14, 0, mk(2, 0, 32'hCAFEBEEF, 0, 0, 0, 0));

    // Errors: misaligned, out of range, illegal size
    xact(1, SZ_H, 0, 32'h9, 32'hFFFF, mk(1, 1, 32'h0, 0, 0, 0, 0));
    xact(0, SZ_W, 0, 32'h100, 0, mk(1, 1, 32'h0, 0, 0, 0, 0));
    xact(0, 2'b11, 0, 32'h0, 0, mk(1, 1, 32'h0, 0, 0, 0, 0));
    xact(0, SZ_W, 0, 32'h2, 0, mk(1, 1, 32'h0, 0, 0, 0, 0));
    xact(1, SZ_B, 0, 32'h200, 32'h77, mk(1, 1, 32'h0, 0, 0, 0, 0));
    xact(1, 2'b11, 0, 32'h8, 32'h77, mk(1, 1, 32'h0, 0, 0, 0, 0));

    // Last in-range word
    xact(0, SZ_W, 0, 32'hFC, 0, mk(2, 0, 32'h0, 0, 0, 0, 0));
    xact(0, SZ_B, 1, 32'hFF, 0, mk(2, 0, 32'h0, 0, 0, 0, 0));

    // Response back-pressure with a competing request
    n = rsp_seen;
    rsp_ready = 1'b0;
    issue(0, SZ_W, 0, 32'h8, 0, mk(2, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    exp_q.push_back(mk(2, 0, 32'hDE12BEEF, 0, 0, 0, 0));
    req_we = 0; req_size = SZ_W; req_unsigned = 0; req_addr = 32'h4; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("stall_rsp_err", 32'(rsp_err), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(n + 1);

    // Reset during the write cycle of a sub-word store
    req_we = 1; req_size = SZ_H; req_unsigned = 0; req_addr = 32'hA; req_wdata = 32'hCAFE;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_state", 32'(dbg_state), 32'(ST_WR));
    rst_n = 1'b0;
    #1;
    check("rst_wr_mem_we", 32'(mem_we), 32'd0);
    check("rst_wr_mem_wd", mem_wd, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_wr_word2", mem[2], 32'hDEADBEEF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);
    check("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    xact(0, SZ_W, 0, 32'h8, 0, mk(2, 0, 32'hDEADBEEF, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
# dmem_lsu_ctrl

Load/store sequencer between the core's memory stage and the word-addressed data memory. Accepts byte, halfword and word loads and stores over a valid/ready handshake. Sub-word stores run as read-modify-write, because the memory has word-only synchronous writes and combinational reads. Also handles load sign/zero extension and rejects misaligned or out-of-range accesses.

## Interface
- `MEM_WORDS`, default 64: memory depth in 32-bit words. An access is in range when `addr[31:2] < MEM_WORDS`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: zero-extend loads. Ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid` at a rising edge.
- `rsp_rdata` out 32: extended load data. 0 for stores and errors.
- `rsp_err` out 1: misaligned, illegal-size or out-of-range access.
- `mem_a` out 32: memory byte address, word-aligned (`{addr[31:2],2'b00}`).
- `mem_wd` out 32: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_rd` in 32: memory read data, combinational from `mem_a`.

## Operation
- States: IDLE, RD, WR, RESP.
  - `req_ready` = (state == IDLE).
  - `rsp_valid` = (state == RESP).
- IDLE, on accept: latch we, size, unsigned, addr and wdata. Then check the request.
  - Error if size = 11, size = 01 with addr[0] = 1, size = 10 with addr[1:0] ≠ 0, or addr[31:2] ≥ MEM_WORDS.
  - Error → RESP with `rsp_err` = 1.
  - Load or sub-word store → RD.
  - Word store → WR.
- RD: drive `mem_a`. Capture `mem_rd` into the data register at the clock edge.
  - Load → RESP. The data register holds the extracted and extended value:
    - byte lane = addr[1:0]; half lane = addr[1].
    - Sign-extend unless `req_unsigned` is set.
  - Sub-word store → WR. The data register holds the merged word: the addressed byte or half is replaced by wdata[7:0] or wdata[15:0], other lanes are kept.
- WR: `mem_we` = 1 for exactly this one cycle.
  - `mem_wd` = wdata for word stores, or the merged word for sub-word stores.
  - Next state is RESP.
- RESP: hold `rsp_rdata` and `rsp_err` stable until `rsp_ready`, then → IDLE.
  - `req_ready` = 0 throughout RESP, so a request arriving in the same cycle as `rsp_ready` is accepted on the following IDLE cycle.
- Idle outputs:
  - `mem_a` = 0 outside RD and WR.
  - `mem_wd` = 0 outside WR.
  - `mem_we` = 0 outside WR.
  - An errored request never asserts `mem_we`.
- Reset values: state = IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `mem_a` = 0, `mem_wd` = 0, `mem_we` = 0.
- Reset mid-operation: the state returns to IDLE asynchronously and the pending response is discarded.
  - Reset asserted during WR before the edge: `mem_we` falls immediately and no write occurs, so the memory word keeps its old value.
  - A sub-word store is never half-applied.

## Timing
- Accept edge = cycle 0.
- Error: `rsp_valid` from cycle 1.
- Load: RD in cycle 1, `rsp_valid` from cycle 2.
- Word store: WR in cycle 1 (write at the end of cycle 1), `rsp_valid` from cycle 2.
- Sub-word store: RD in cycle 1, WR in cycle 2, `rsp_valid` from cycle 3.
- Throughput: at most one request in flight. With `rsp_ready` tied high, back-to-back loads complete every 3 cycles.
- `mem_rd` is sampled only at the RD clock edge. The memory read path is combinational, so no wait states are needed.

## Structure
- Package `dmem_lsu_pkg` holds:
  - Size encodings SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
  - The state enum.
  - Function prototypes for load extract/extend and store merge.
- One sub-module, `dmem_lsu_fmt`, purely combinational:
  - Inputs: `size`, `unsigned`, `addr[1:0]`, `word_in`, `wdata`.
  - Outputs: `load_val` and `merged`.
- The FSM and registers stay in `dmem_lsu_ctrl`.

## Test plan
Memory model is 64 words, preloaded with words 0–8 = 0xDEADBEEF.
- lw 0x0 → `rsp_rdata` 0xDEADBEEF, `rsp_err` 0, `rsp_valid` at cycle 2, `mem_we` never asserted.
- lb 0x1 → 0xFFFFFFBE. lbu 0x1 → 0x000000BE. lh 0x2 → 0xFFFFDEAD. lhu 0x2 → 0x0000DEAD.
- sb 0x6 data 0x12 → one `mem_we` pulse in cycle 2 with `mem_a` 0x4 and `mem_wd` 0xDE12BEEF; `rsp_valid` at cycle 3. A following lw 0x4 returns 0xDE12BEEF.
- sh 0x9 → `rsp_err` 1 at cycle 1. lw 0x100 → `rsp_err` 1. req_size 11 → `rsp_err` 1. In all three cases `mem_we` stays 0 and `rsp_rdata` = 0.
- lw 0x8 with `rsp_ready` low for 5 cycles → `rsp_valid`, `rsp_rdata` 0xDEADBEEF and `req_ready` 0 held stable. A new `req_valid` is accepted only the cycle after the handshake.
- sh 0xA data 0xCAFE with `rst_n` dropped mid-WR → `mem_we` falls immediately, word 2 stays 0xDEADBEEF, and after release `req_ready` = 1 and `rsp_valid` = 0.
